// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared AES definitions.
//   aes_byte_t / aes_state_t : 8-bit byte and 128-bit state types
//   AES_POLY                 : low byte of the reduction polynomial 0x11B
//   SBOX                     : FIPS-197 forward S-box, indexed by input byte
//   xtime / gf_mul3          : GF(2^8) multiply by {02} and {03}
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    localparam aes_byte_t AES_POLY = 8'h1B;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by {02}: shift left, fold the carried-out bit back via 0x1B.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by {03} = {02} xor {01}.
    function automatic aes_byte_t gf_mul3(input aes_byte_t b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox -- combinational AES forward S-box lookup.
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_ar_round.sv
// ---------------------------------------------------------------------------
// aes_ar_round -- one registered AES encryption round, 1-cycle latency.
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset, clears ciphertextout
//   enable        : capture the round result on the next rising edge
//   key           : 128-bit round key, byte 0 = key[127:120]
//   plaintext     : 128-bit input state, column-major, byte 0 = [127:120]
//   ciphertextout : registered round result, same byte order
//
// Build option AES_MIXCOLUMNS_EN:
//   defined   -> full round  (SubBytes, ShiftRows, MixColumns, AddRoundKey)
//   undefined -> final round (SubBytes, ShiftRows, AddRoundKey)
//
// Transfer semantics: there is no handshake. Every rising edge with
// enable=1 (and rst low) loads a new result; enable=0 holds the register.
// ---------------------------------------------------------------------------
module aes_ar_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] ciphertextout
);

    aes_byte_t  w_sub   [16];
    aes_byte_t  w_shift [16];
    aes_byte_t  w_mix   [16];
    aes_state_t w_next;
    aes_state_t r_state;

    // Byte i lives at bits [127-8i -: 8]; row = i % 4, column = i / 4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;

        aes_sbox u_sbox (
            .i_byte (plaintext[127-8*gi -: 8]),
            .o_byte (w_sub[gi])
        );

        // Row r rotates left by r: output column c takes input column c+r.
        assign w_shift[gi] = w_sub[((COL + ROW) % 4) * 4 + ROW];

        assign w_next[127-8*gi -: 8] = w_mix[gi] ^ key[127-8*gi -: 8];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        aes_byte_t w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_shift[4*gc + 0];
        assign w_a1 = w_shift[4*gc + 1];
        assign w_a2 = w_shift[4*gc + 2];
        assign w_a3 = w_shift[4*gc + 3];
`ifdef AES_MIXCOLUMNS_EN
        // {02,03,01,01} circulant applied to one column.
        assign w_mix[4*gc + 0] = xtime(w_a0)   ^ gf_mul3(w_a1) ^ w_a2          ^ w_a3;
        assign w_mix[4*gc + 1] = w_a0          ^ xtime(w_a1)   ^ gf_mul3(w_a2) ^ w_a3;
        assign w_mix[4*gc + 2] = w_a0          ^ w_a1          ^ xtime(w_a2)   ^ gf_mul3(w_a3);
        assign w_mix[4*gc + 3] = gf_mul3(w_a0) ^ w_a1          ^ w_a2          ^ xtime(w_a3);
`else
        assign w_mix[4*gc + 0] = w_a0;
        assign w_mix[4*gc + 1] = w_a1;
        assign w_mix[4*gc + 2] = w_a2;
        assign w_mix[4*gc + 3] = w_a3;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    assign ciphertextout = r_state;

endmodule

// File: tb/tb_aes_ar_round.sv
// ---------------------------------------------------------------------------
// tb_aes_ar_round -- scoreboard bench for aes_ar_round.
// The reference model derives the S-box from the GF(2^8) inverse plus the
// affine map and works on a 4x4 byte matrix. Build with or without
// AES_MIXCOLUMNS_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_aes_ar_round;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;
    logic [127:0] ciphertextout;

    aes_ar_round dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key           (key),
        .plaintext     (plaintext),
        .ciphertextout (ciphertextout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] res;
        int coef [4];
        coef = '{2, 3, 1, 1};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = sb[pt[127-8*(4*c+r) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c + r) % 4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
`ifdef AES_MIXCOLUMNS_EN
                m[r][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    m[r][c] = m[r][c] ^ gmul(8'(coef[(j - r + 4) % 4]), t[j][c]);
`else
                m[r][c] = t[r][c];
`endif
                res[127-8*(4*c+r) -: 8] = m[r][c] ^ k[127-8*(4*c+r) -: 8];
            end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] exp);
        @(posedge clk);
        #1;
        enable    = en;
        plaintext = pt;
        key       = k;
        if (en && !rst) exp_q.push_back(exp);
    endtask

    task automatic drive_rand(input logic en);
        logic [127:0] pt, k;
        pt = rand128();
        k  = rand128();
        drive(en, pt, k, ref_round(pt, k));
    endtask

    // ---------------- monitor ----------------
    logic         cap_at_edge = 1'b0;
    logic         rst_at_edge = 1'b0;
    logic [127:0] last_exp    = '0;

    always @(posedge clk) begin
        cap_at_edge = enable && !rst;
        rst_at_edge = rst;
    end

    always @(negedge clk) begin
        logic [127:0] e;
        if (rst || rst_at_edge) begin
            // A capture overtaken by reset is discarded.
            if (cap_at_edge && exp_q.size() > 0) e = exp_q.pop_front();
            last_exp = '0;
            check("reset_out", ciphertextout, '0);
        end else if (cap_at_edge) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL capture: got %h expected <none queued> at %0t", ciphertextout, $time);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                check("capture", ciphertextout, e);
            end
        end else begin
            check("hold", ciphertextout, last_exp);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] pt, k, e;
        build_sbox();

        // Power-up reset, checked asynchronously before any clock edge.
        #1 rst = 1'b1;
        #1 check("async_reset_init", ciphertextout, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed known-answer vector for the compiled round variant.
`ifdef AES_MIXCOLUMNS_EN
        drive(1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'ha49c7ff2689f352b6b5bea43026a5049);
`else
        drive(1'b1, 128'heb40f21e592e38848ba113e71bc342d2,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    128'h3925841d02dc09fbdc118597196a0b32);
`endif

        // Zero vector: every byte becomes S-box(0) = 0x63.
        drive(1'b1, '0, '0, {16{8'h63}});

        // Hold: inputs wander while enable is low.
        repeat (10) drive_rand(1'b0);

        // Streaming: a new vector every cycle.
        repeat (16) drive_rand(1'b1);

        // Reset mid-operation with a capture pending.
        pt = rand128();
        k  = rand128();
        e  = ref_round(pt, k);
        drive(1'b1, pt, k, e);
        @(posedge clk);
        #1;
        enable    = 1'b1;
        plaintext = rand128();
        key       = rand128();
        check("pre_reset_out", ciphertextout, e);
        #1 rst = 1'b1;
        #1 check("async_reset_mid", ciphertextout, '0);
        repeat (3) drive_rand(1'b1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b0;
        repeat (2) drive_rand(1'b0);

        drive(1'b1, '0, '0, {16{8'h63}});

        // Random mix of captures and holds.
        repeat (80) drive_rand(1'($urandom_range(0, 1)));

        // Drain.
        repeat (3) drive_rand(1'b0);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
